add_2p_arb: RTL and testbench
=============================

Name: add_2p_arb

Overview:
- Shares one external 22-bit pipelined adder (fixed LATENCY-cycle input-to-sum path, no stall) between NREQ requesters.
- Each cycle: at most one request granted by round-robin; its operands driven to the adder; a valid/ID tag travels alongside.
- Sum returned to the owning requester exactly LATENCY cycles later.
- Includes an enable/drain FSM so software can quiesce the adder before reconfiguration.

Parameters:
- WIDTH, 22, operand/sum bit width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, ceil(log2(NREQ)).
- LATENCY, 4, adder clock cycles from add_x/add_y to add_sum (1..8).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = grants allowed; 0 = finish in-flight work, then idle.
- req  in  NREQ  per-requester request level.
- x_in  in  NREQ*WIDTH  operand x, requester i at bits [i*WIDTH +: WIDTH].
- y_in  in  NREQ*WIDTH  operand y, same packing.
- ack  out  NREQ  one-hot grant pulse; operands sampled this cycle.
- add_x  out  WIDTH  operand x to shared adder.
- add_y  out  WIDTH  operand y to shared adder.
- add_sum  in  WIDTH  adder result.
- res_valid  out  1  result valid.
- res_id  out  IDW  owner of the result.
- res_sum  out  WIDTH  result, equal to add_sum when res_valid is high.
- idle  out  1  FSM in IDLE and pipeline empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - ack=0, add_x=0, add_y=0, res_valid=0, res_id=0, res_sum=0.
  - Tag pipe cleared, rr pointer=0, FSM=IDLE, idle=1.
  - Reset asserted mid-operation discards in-flight tags; no result is ever reported for them.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> DRAIN.
  - DRAIN: tag pipe empty -> IDLE; en=1 -> RUN (resume immediately, no wait).
  - idle=1 only in IDLE.
- Grants happen only in RUN, combinationally in the cycle they are decided:
  - Search req starting at rr pointer, wrapping NREQ-1 -> 0; first set bit wins.
  - ack[winner]=1 for that cycle only (combinational, same cycle).
  - Registered on the same edge: add_x/add_y <= winner's operands; tag stage0 <= {1, winner ID}.
  - rr pointer <= winner+1 mod NREQ.
  - No winner: tag stage0 valid=0; add_x/add_y hold their previous values; pointer unchanged.
- Requester protocol:
  - Holds req and operands until it sees ack.
  - Deasserts req the cycle after ack, or keeps req high to issue back-to-back; one grant per ack.
- Tag pipe:
  - Shift register of LATENCY-1 entries beyond stage0, so the tag lines up with add_sum.
  - res_valid/res_id/res_sum are registered outputs: updated the cycle the aligned tag is present, visible one edge later.
  - Total req-granted to res_valid latency = LATENCY+1 cycles.
- Throughput: one grant per cycle. Every requester continuously requesting gets a grant within NREQ cycles.
- Arithmetic: add_sum is passed through unmodified, i.e. modulo 2^WIDTH (carry-out dropped).
- Boundary cases:
  - en falls in the same cycle as a grant decision: that grant still issues.
  - en=0 and req=0 with an empty pipe in RUN: DRAIN for one cycle, then IDLE.
  - NREQ not a power of 2: pointer wraps at NREQ, not 2^IDW.

Optional Feature:
- ADD_2P_ARB_STATS_EN defined:
  - Adds output grant_cnt (NREQ*16 bits): per-requester saturating grant counters, saturating at 16'hFFFF.
  - Cleared by reset and whenever the FSM enters IDLE.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Single request: en=1, req=4'b0001, x=22'h000001, y=22'h0003FF -> ack[0] pulses same cycle; 5 cycles later res_valid=1, res_id=0, res_sum=22'h000400.
- Round-robin: req=4'b1111 held for 8 cycles -> ack order 0,1,2,3,0,1,2,3; res_id sequence identical, delayed 5 cycles.
- Wrap-around sum: x=22'h3FFFFF, y=22'h000001 -> res_sum=22'h000000.
- Drain: issue 3 back-to-back grants, then drop en -> no further ack; all 3 results appear; idle=1 one cycle after the last tag leaves.
- Reset mid-flight: 2 grants issued, reset pulsed low 1 cycle before the first result -> no res_valid afterwards; after re-enable the first grant goes to requester 0.
- STATS (macro defined): 10 grants to requester 2 -> grant_cnt[2]=10, others 0; cleared after a drain to IDLE.

Source files
------------

// File: rtl/add_2p_arb.sv
// Round-robin arbiter sharing one pipelined adder among NREQ requesters, with enable/drain FSM.
// Define ADD_2P_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module add_2p_arb #(
  parameter int WIDTH   = 22,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] x_in,
  input  logic [NREQ*WIDTH-1:0] y_in,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      add_x,
  output logic [WIDTH-1:0]      add_y,
  input  logic [WIDTH-1:0]      add_sum,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_sum,
`ifdef ADD_2P_ARB_STATS_EN
  output logic [NREQ*16-1:0]    grant_cnt,
`endif
  output logic                  idle
);

  // Tag stages 0..STAGES; the last stage is aligned with add_sum.
  localparam int STAGES = LATENCY - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [IDW-1:0]             rr, rr_nxt, win;
  logic                       found, grant, pipe_empty;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][IDW-1:0]   id_pipe;

  assign pipe_empty = ~|vld_pipe;
  assign idle       = (state == S_IDLE) && pipe_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = S_DRAIN;
      S_DRAIN: if (en) state_nxt = S_RUN;
               else if (pipe_empty) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Search starts at rr and wraps at NREQ (not 2^IDW).
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr) + k) % NREQ);
      end
    end
  end

  assign grant  = (state == S_RUN) && found;
  assign rr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

  always_comb begin
    ack = '0;
    if (grant) ack[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr        <= '0;
      add_x     <= '0;
      add_y     <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        add_x <= x_in[int'(win)*WIDTH +: WIDTH];
        add_y <= y_in[int'(win)*WIDTH +: WIDTH];
        rr    <= rr_nxt;
      end
      vld_pipe[0] <= grant;
      id_pipe[0]  <= win;
      for (int k = STAGES; k >= 1; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      res_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        res_id  <= id_pipe[STAGES];
        res_sum <= add_sum;
      end
    end
  end

`ifdef ADD_2P_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt;
  assign grant_cnt = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state != S_IDLE && state_nxt == S_IDLE) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (ack[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add_2p_arb.sv
// Directed bench for add_2p_arb: latency, round-robin order, wrap-around sum, drain, reset, NREQ=3 wrap.
module tb_add_2p_arb;
  localparam int W = 22, N = 4, IW = 2, L = 4;

  logic             clk = 1'b0;
  logic             reset, en;
  logic [N-1:0]     req, ack;
  logic [N*W-1:0]   x_in, y_in;
  logic [W-1:0]     add_x, add_y, add_sum, res_sum;
  logic             res_valid, idle;
  logic [IW-1:0]    res_id;
`ifdef ADD_2P_ARB_STATS_EN
  logic [N*16-1:0]  grant_cnt;
  logic [3*16-1:0]  grant_cnt3;
`endif

  // Second instance with a non-power-of-2 requester count
  logic [2:0]       req3, ack3;
  logic [3*W-1:0]   x_in3, y_in3;
  logic [W-1:0]     add_x3, add_y3, res_sum3;
  logic [W-1:0]     add_sum3 = '0;
  logic             res_valid3, idle3;
  logic [1:0]       res_id3;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  add_2p_arb #(.WIDTH(W), .NREQ(N), .IDW(IW), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .x_in(x_in), .y_in(y_in),
    .ack(ack), .add_x(add_x), .add_y(add_y), .add_sum(add_sum),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
`ifdef ADD_2P_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .idle(idle));

  add_2p_arb #(.WIDTH(W), .NREQ(3), .IDW(2), .LATENCY(L)) dut3 (
    .clk(clk), .reset(reset), .en(en), .req(req3), .x_in(x_in3), .y_in(y_in3),
    .ack(ack3), .add_x(add_x3), .add_y(add_y3), .add_sum(add_sum3),
    .res_valid(res_valid3), .res_id(res_id3), .res_sum(res_sum3),
`ifdef ADD_2P_ARB_STATS_EN
    .grant_cnt(grant_cnt3),
`endif
    .idle(idle3));

  // External adder model: L-1 register stages after add_x/add_y, so its sum meets the last tag stage
  logic [W-1:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= add_x + add_y;
    s2 <= s1;
    s3 <= s2;
  end
  assign add_sum = s3;

  logic [W-1:0] rr_sum [N] = '{22'h100000, 22'h100101, 22'h100202, 22'h100303};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_ops();
    for (int j = 0; j < N; j++) begin
      x_in[j*W +: W] = 22'h100000 + W'(j);
      y_in[j*W +: W] = W'(j) << 8;
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; req = '0; x_in = '0; y_in = '0;
    req3 = '0; x_in3 = '0; y_in3 = '0;
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_add_x", add_x, 0);
    chk("rst_add_y", add_y, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_idle", idle, 1);
    tick();
    reset = 1'b1;

    // Single request: ack same cycle, result LATENCY+1 cycles later
    en = 1'b1;
    tick();
    chk("t1_run_idle", idle, 0);
    req = 4'b0001; x_in[0 +: W] = 22'h000001; y_in[0 +: W] = 22'h0003FF;
    #1;
    chk("t1_ack", ack, 4'b0001);
    tick();
    req = '0;
    chk("t1_add_x", add_x, 22'h000001);
    chk("t1_add_y", add_y, 22'h0003FF);
    for (int c = 1; c < 5; c++) begin
      chk("t1_early_valid", res_valid, 0);
      tick();
    end
    chk("t1_valid", res_valid, 1);
    chk("t1_id", res_id, 0);
    chk("t1_sum", res_sum, 22'h000400);
    tick();
    chk("t1_valid_pulse", res_valid, 0);

    // Round-robin with all four requesting for 8 cycles
    do_reset();
    tick();
    set_ops();
    for (int i = 0; i < 14; i++) begin
      req = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ack", ack, (i < 8) ? (32'd1 << (i % 4)) : 32'd0);
      chk("rr_valid", res_valid, (i >= 5 && i < 13) ? 1 : 0);
      if (i >= 5 && i < 13) begin
        chk("rr_id", res_id, (i - 5) % 4);
        chk("rr_sum", res_sum, rr_sum[(i - 5) % 4]);
      end
      tick();
    end

    // Carry out of the top bit is dropped
    x_in[0 +: W] = 22'h3FFFFF; y_in[0 +: W] = 22'h000001;
    for (int i = 0; i < 7; i++) begin
      req = (i == 0) ? 4'b0001 : 4'b0000;
      #1;
      chk("wrap_ack", ack, (i == 0) ? 1 : 0);
      chk("wrap_valid", res_valid, (i == 5) ? 1 : 0);
      if (i == 5) begin
        chk("wrap_id", res_id, 0);
        chk("wrap_sum", res_sum, 22'h000000);
      end
      tick();
    end

    // Drain: grants to 1,2,3; en drops during the third grant cycle
    set_ops();
    for (int i = 0; i < 10; i++) begin
      req = (i <= 3) ? 4'b1111 : 4'b0000;
      en  = (i < 2);
      #1;
      chk("drain_ack", ack, (i < 3) ? (32'd1 << (i + 1)) : 32'd0);
      chk("drain_valid", res_valid, (i >= 5 && i <= 7) ? 1 : 0);
      if (i >= 5 && i <= 7) begin
        chk("drain_id", res_id, i - 4);
        chk("drain_sum", res_sum, rr_sum[i - 4]);
      end
      chk("drain_idle", idle, (i >= 8) ? 1 : 0);
      tick();
    end

    // Reset one cycle before the first result; nothing may emerge, pointer back at 0
    en = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      req   = (i < 2 || i == 10) ? 4'b1111 : 4'b0000;
      reset = (i != 4);
      #1;
      chk("mid_ack", ack, (i == 0 || i == 10) ? 1 : (i == 1) ? 2 : 0);
      chk("mid_idle", idle, (i == 4 || i == 5) ? 1 : 0);
      chk("mid_valid", res_valid, (i == 15) ? 1 : 0);
      if (i == 15) chk("mid_id", res_id, 0);
      tick();
    end

    // en=0 with nothing in flight: one DRAIN cycle, then IDLE
    en = 1'b0;
    tick();
    chk("quick_drain_idle", idle, 0);
    tick();
    chk("quick_idle", idle, 1);

    // Three requesters: pointer wraps at 3
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      req3 = 3'b111;
      #1;
      chk("n3_ack", ack3, 32'd1 << (i % 3));
      tick();
    end
    req3 = '0;

`ifdef ADD_2P_ARB_STATS_EN
    do_reset();
    tick();
    for (int i = 0; i < 10; i++) begin
      req = 4'b0100;
      tick();
    end
    req = '0;
    #1;
    chk("cnt0", grant_cnt[0 +: 16], 0);
    chk("cnt1", grant_cnt[16 +: 16], 0);
    chk("cnt2", grant_cnt[32 +: 16], 10);
    chk("cnt3", grant_cnt[48 +: 16], 0);
    en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("cnt_idle", idle, 1);
    chk("cnt_clear", grant_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
